// File: rtl/cpu_run_ctrl.sv
// CPU clock/reset sequencer: programmable clock divider, free-run / single-step /
// burst / halt modes, step-key debounce and reset sequencing on ROM change.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 16,
  parameter int CNT_W           = 25
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic [CNT_W-1:0] cpu_speed,
  input  logic [1:0]       mode,
  input  logic [7:0]       burst_len,
  input  logic             step_key,
  input  logic             rom_selector,
  output logic             clk_cpu,
  output logic             cpu_rst,
  output logic             busy,
  output logic [31:0]      cycle_cnt
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RST_W = $clog2(RST_HOLD + 1);

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_IDLE = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  localparam logic [1:0] M_FREE  = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;

  logic [1:0]       key_sync, rom_sync;
  logic             key_db, step_req, rom_prev;
  logic [DB_W-1:0]  db_cnt;
  logic [1:0]       state;
  logic [RST_W-1:0] rst_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic [8:0]       remaining;
  logic             rom_change, run_en, tick, rise, fall;

  always_ff @(posedge clk50M) begin
    key_sync <= {key_sync[0], step_key};
    rom_sync <= {rom_sync[0], rom_selector};
  end

  // Level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      key_db   <= 1'b0;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (key_sync[1] == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db   <= key_sync[1];
        db_cnt   <= '0;
        step_req <= key_sync[1];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign rom_change = (rom_sync[1] != rom_prev);
  assign run_en     = (state != S_IDLE);
  assign tick       = (div_cnt >= cpu_speed);
  assign rise       = run_en & tick & ~clk_cpu;
  assign fall       = run_en & tick &  clk_cpu;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk50M) begin
    if (rst) begin
      clk_cpu   <= 1'b0;
      cpu_rst   <= 1'b1;
      cycle_cnt <= '0;
      state     <= S_RST;
      rst_cnt   <= RST_W'(RST_HOLD);
      div_cnt   <= '0;
      remaining <= '0;
      rom_prev  <= rom_sync[1];
    end else begin
      rom_prev <= rom_sync[1];

      // The divider keeps running through a ROM-change reset, so the phase is preserved.
      if (!run_en) begin
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        clk_cpu <= ~clk_cpu;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (cpu_rst)   cycle_cnt <= '0;
      else if (rise) cycle_cnt <= cycle_cnt + 1'b1;

      if (rom_change) begin
        cpu_rst <= 1'b1;
        rst_cnt <= RST_W'(RST_HOLD);
        state   <= S_RST;
      end else begin
        case (state)
          S_RST: begin
            if (rise && rst_cnt != '0) begin
              rst_cnt <= rst_cnt - 1'b1;
            end else if (fall && rst_cnt == '0) begin
              cpu_rst <= 1'b0;
              state   <= (mode == M_FREE) ? S_RUN : S_IDLE;
            end
          end
          S_RUN: begin
            if (fall && mode != M_FREE) state <= S_IDLE;
          end
          S_IDLE: begin
            if (mode == M_FREE) begin
              state <= S_RUN;
            end else if (step_req && mode == M_STEP) begin
              remaining <= 9'd1;
              state     <= S_STEP;
            end else if (step_req && mode == M_BURST) begin
              remaining <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
              state     <= S_STEP;
            end
          end
          default: begin
            if (fall) begin
              remaining <= remaining - 1'b1;
              if (remaining == 9'd1) state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
